mem_access_stage: RTL and testbench

- Memory stage of the 16-bit MISC-V pipeline, sitting directly downstream of the EX/MEM register.
- Consumes the EX/MEM control and data outputs and performs the data-memory load or store over a req/ack handshake.
- Stalls the upstream stages while an access is outstanding.
- Registers its results into MEM/WB outputs, which feed writeback.

---
 rtl/mem_access_stage_pkg.sv | 19 +
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage_mem_wb_reg.sv | 56 +++++
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared state, width and MEM/WB bubble definitions for the memory stage
package mem_access_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic reg_store;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, reg_store: 1'b0};

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the memory stage and the data memory
interface mem_access_stage_if #(
  parameter int DATA_W = mem_access_pkg::DATA_W
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// rtl/mem_access_stage_mem_wb_reg.sv - MEM/WB pipeline register with load-enable and bubble insert
module mem_wb_reg
  import mem_access_pkg::*;
#(
  parameter int DATA_W = mem_access_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              bubble,
  input  wb_ctrl_t          ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] rd_in,
  output wb_ctrl_t          ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] rd_out
);

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    rd_d   = rd_q;
    if (bubble) begin
      ctrl_d = WB_BUBBLE;
      data_d = '0;
      rd_d   = '0;
    end else if (load_en) begin
      ctrl_d           = ctrl_in;
      // A register write must never escape without a valid instruction behind it
      ctrl_d.reg_write = ctrl_in.valid & ctrl_in.reg_write;
      data_d           = data_in;
      rd_d             = rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= WB_BUBBLE;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      rd_q   <= rd_d;
    end
  end

  assign ctrl_out = ctrl_q;
  assign data_out = data_q;
  assign rd_out   = rd_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory req/ack FSM, upstream stall, MEM/WB results; MEM_ACCESS_TIMEOUT_EN adds WAIT abort and sticky mem_fault
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DATA_W = mem_access_pkg::DATA_W
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_store,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_rd,
  output logic              mem_stall,
  mem_access_stage_if.master dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_reg_store,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_rd
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic              mem_fault
`endif
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              rs_q, rs_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  logic              memop;
  logic              stall_c;
  logic              wb_load;
  wb_ctrl_t          wb_ctrl_in;
  logic [DATA_W-1:0] wb_data_in;
  logic [DATA_W-1:0] wb_rd_in;
  wb_ctrl_t          wb_ctrl;

  assign memop = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    rs_d       = rs_q;
    stall_c    = 1'b0;
    wb_load    = 1'b0;
    wb_ctrl_in = '{valid: 1'b1, reg_write: ex_reg_write, reg_store: ex_reg_store};
    wb_data_in = ex_alu_result;
    wb_rd_in   = ex_rd;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = fault_q;
`endif
    if (state_q == IDLE) begin
      if (memop) begin
        // Write wins when both read and write are set
        stall_c = 1'b1;
        state_d = WAIT;
        req_d   = 1'b1;
        we_d    = ex_mem_write;
        addr_d  = ex_alu_result;
        wdata_d = ex_store_data;
        rd_d    = ex_rd;
        rw_d    = ex_reg_write;
        rs_d    = ex_reg_store;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end else if (ex_valid) begin
        wb_load = 1'b1;
      end
    end else begin
      if (dmem.dmem_ack) begin
        state_d    = IDLE;
        req_d      = 1'b0;
        wb_load    = 1'b1;
        wb_ctrl_in = '{valid: 1'b1, reg_write: rw_q, reg_store: rs_q};
        wb_data_in = we_q ? addr_q : dmem.dmem_rdata;
        wb_rd_in   = rd_q;
      end else begin
        stall_c = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        // Abort squashes the instruction: bubble into MEM/WB, let upstream move on
        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          fault_d = 1'b1;
          stall_c = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .load_en  (wb_load),
    .bubble   (!wb_load),
    .ctrl_in  (wb_ctrl_in),
    .data_in  (wb_data_in),
    .rd_in    (wb_rd_in),
    .ctrl_out (wb_ctrl),
    .data_out (wb_data),
    .rd_out   (wb_rd)
  );

  assign mem_stall       = stall_c;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_valid        = wb_ctrl.valid;
  assign wb_reg_write    = wb_ctrl.reg_write;
  assign wb_reg_store    = wb_ctrl.reg_store;
`ifdef MEM_ACCESS_TIMEOUT_EN
  assign mem_fault       = fault_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage; MEM_ACCESS_TIMEOUT_EN adds a TIMEOUT=4 instance
module tb_mem_access_stage;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_reg_store;
  logic [W-1:0] ex_alu_result, ex_store_data, ex_rd;
  logic         mem_stall, wb_valid, wb_reg_write, wb_reg_store;
  logic [W-1:0] wb_data, wb_rd;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_stage_if #(.DATA_W(W)) bus ();

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic mem_fault;
`endif

  mem_access_stage #(.DATA_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_store  (ex_reg_store),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .mem_stall     (mem_stall),
    .dmem          (bus),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_reg_store  (wb_reg_store),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd)
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    .mem_fault     (mem_fault)
`endif
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_access_stage_if #(.DATA_W(W)) tbus ();
  logic         t_stall, t_wb_valid, t_wb_rw, t_wb_rs, t_fault;
  logic [W-1:0] t_wb_data, t_wb_rd;

  mem_access_stage #(.DATA_W(W), .TIMEOUT(4)) dut_to (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_store  (ex_reg_store),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .mem_stall     (t_stall),
    .dmem          (tbus),
    .wb_valid      (t_wb_valid),
    .wb_reg_write  (t_wb_rw),
    .wb_reg_store  (t_wb_rs),
    .wb_data       (t_wb_data),
    .wb_rd         (t_wb_rd),
    .mem_fault     (t_fault)
  );
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] rd;
    logic         rw;
    logic         rs;
  } wb_exp_t;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         we;
  } mop_t;

  wb_exp_t wbq[$];
  mop_t    mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic mr, input logic mw,
                          input logic rs, input logic [W-1:0] alu, input logic [W-1:0] sd,
                          input logic [W-1:0] rd);
    ex_valid      = v;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_store  = rs;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
  endtask

  task automatic bubble_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    logic [4*W+6:0] v;
    reset = 1'b1;
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h1111, 16'h0002);
    bus.dmem_ack = 1'b1;
    tick();
    tick();
    bubble_ex();
    bus.dmem_ack = 1'b0;
    settle();
    v = {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, wb_valid, wb_reg_write,
         wb_reg_store, wb_data, wb_rd, mem_stall};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", v);
    end
    tick();
    reset = 1'b0;
    tick();
    settle();
    v = {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, wb_valid, wb_reg_write,
         wb_reg_store, wb_data, wb_rd, mem_stall};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected 0", v);
    end
    tick();
  endtask

  task automatic test_alu_op();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0003);
    settle();
    n_cmp++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_stall: got %b expected 0", mem_stall);
    end
    tick();
    bubble_ex();
    settle();
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd, mem_stall} !==
        {1'b1, 1'b1, 1'b0, 16'h1234, 16'h0003, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_wb: got v=%b rw=%b rs=%b data=%h rd=%h expected 1 1 0 1234 0003",
               wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd);
    end
    tick();
    settle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_wb_once: got wb_valid=%b expected 0", wb_valid);
    end
    tick();
  endtask

  task automatic test_load_delay();
    int stall_cnt = 0;
    int req_cnt = 0;
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h9999, 16'h0005);
    for (int c = 0; c < 4; c++) begin
      bus.dmem_ack   = (c == 3);
      bus.dmem_rdata = (c == 3) ? 16'hBEEF : 16'h0000;
      settle();
      if (mem_stall) stall_cnt++;
      if (bus.dmem_req) begin
        req_cnt++;
        n_cmp++;
        if ({bus.dmem_addr, bus.dmem_we} !== {16'h0040, 1'b0}) begin
          n_fail++;
          $display("FAIL load_req_fields: got addr=%h we=%b expected 0040 0",
                   bus.dmem_addr, bus.dmem_we);
        end
      end
      n_cmp++;
      if ({wb_valid, wb_reg_write} !== 2'b00) begin
        n_fail++;
        $display("FAIL load_bubble c%0d: got v=%b rw=%b expected 0 0", c, wb_valid, wb_reg_write);
      end
      tick();
    end
    bubble_ex();
    bus.dmem_ack = 1'b0;
    settle();
    n_cmp++;
    if (stall_cnt != 3 || req_cnt != 3) begin
      n_fail++;
      $display("FAIL load_cycles: got stall=%0d req=%0d expected 3 3", stall_cnt, req_cnt);
    end
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_data, wb_rd} !== {1'b1, 1'b1, 16'hBEEF, 16'h0005}) begin
      n_fail++;
      $display("FAIL load_wb: got v=%b rw=%b data=%h rd=%h expected 1 1 beef 0005",
               wb_valid, wb_reg_write, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_store_same_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 16'h0007);
    bus.dmem_ack = 1'b0;
    settle();
    n_cmp++;
    if ({mem_stall, bus.dmem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_accept: got stall=%b req=%b expected 1 0", mem_stall, bus.dmem_req);
    end
    tick();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 16'hFFFF;
    settle();
    n_cmp++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, mem_stall} !==
        {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0}) begin
      n_fail++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 0010 a5a5 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, mem_stall);
    end
    tick();
    bubble_ex();
    bus.dmem_ack = 1'b0;
    settle();
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd} !==
        {1'b1, 1'b1, 1'b1, 16'h0010, 16'h0007}) begin
      n_fail++;
      $display("FAIL store_wb: got v=%b rw=%b rs=%b data=%h rd=%h expected 1 1 1 0010 0007",
               wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd);
    end
    tick();
    settle();
    n_cmp++;
    if ({bus.dmem_req, wb_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_done: got req=%b v=%b expected 0 0", bus.dmem_req, wb_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000, 16'h0001);
    bus.dmem_ack = 1'b0;
    settle();
    tick();
    settle();
    n_cmp++;
    if ({mem_stall, bus.dmem_req, wb_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_wait: got stall=%b req=%b v=%b expected 1 1 0", mem_stall, bus.dmem_req, wb_valid);
    end
    tick();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 16'h1111;
    settle();
    tick();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'h0002);
    bus.dmem_ack = 1'b0;
    settle();
    n_cmp++;
    if ({wb_valid, wb_data, wb_rd, mem_stall} !== {1'b1, 16'h1111, 16'h0001, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_load_wb: got v=%b data=%h rd=%h stall=%b expected 1 1111 0001 0",
               wb_valid, wb_data, wb_rd, mem_stall);
    end
    tick();
    bubble_ex();
    settle();
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd} !==
        {1'b1, 1'b0, 1'b1, 16'h5555, 16'h0002}) begin
      n_fail++;
      $display("FAIL b2b_alu_wb: got v=%b rw=%b rs=%b data=%h rd=%h expected 1 0 1 5555 0002",
               wb_valid, wb_reg_write, wb_reg_store, wb_data, wb_rd);
    end
    tick();
    settle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_dup: got v=%b expected 0", wb_valid);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0009);
    bus.dmem_ack = 1'b0;
    settle();
    tick();
    settle();
    n_cmp++;
    if (bus.dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_req: got %b expected 1", bus.dmem_req);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bubble_ex();
    settle();
    n_cmp++;
    if ({bus.dmem_req, wb_valid, mem_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_wait_clear: got req=%b v=%b stall=%b expected 0 0 0",
               bus.dmem_req, wb_valid, mem_stall);
    end
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 16'h1234;
    tick();
    bus.dmem_ack = 1'b0;
    settle();
    n_cmp++;
    if ({bus.dmem_req, wb_valid, wb_reg_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_late_ack: got req=%b v=%b rw=%b expected 0 0 0",
               bus.dmem_req, wb_valid, wb_reg_write);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] mem[16];
    logic [W-1:0] ref_mem[16];
    bit           have_cur = 1'b0;
    int           wleft = -1;
    int           kind;
    bit [31:0]    r1, r2;
    logic [W-1:0] a;
    wb_exp_t      e;
    mop_t         m;
    for (int i = 0; i < 16; i++) begin
      r1 = $urandom;
      mem[i] = r1[15:0];
      ref_mem[i] = r1[15:0];
    end
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (!have_cur) begin
        r1 = $urandom;
        r2 = $urandom;
        kind = (cyc < 600) ? $urandom_range(0, 4) : 0;
        a = {12'h000, r1[3:0]};
        case (kind)
          0: drive_ex(1'b0, r2[16], r2[17], r2[18], r2[19], r1[15:0], r1[31:16], r2[15:0]);
          1: begin
            drive_ex(1'b1, r2[16], 1'b0, 1'b0, r2[19], r1[15:0], r1[31:16], r2[15:0]);
            wbq.push_back('{data: r1[15:0], rd: r2[15:0], rw: r2[16], rs: r2[19]});
          end
          2: begin
            drive_ex(1'b1, r2[16], 1'b1, 1'b0, r2[19], a, r1[31:16], r2[15:0]);
            wbq.push_back('{data: ref_mem[a[3:0]], rd: r2[15:0], rw: r2[16], rs: r2[19]});
            mq.push_back('{addr: a, wdata: r1[31:16], we: 1'b0});
          end
          default: begin
            drive_ex(1'b1, r2[16], (kind == 4), 1'b1, r2[19], a, r1[31:16], r2[15:0]);
            ref_mem[a[3:0]] = r1[31:16];
            wbq.push_back('{data: a, rd: r2[15:0], rw: r2[16], rs: r2[19]});
            mq.push_back('{addr: a, wdata: r1[31:16], we: 1'b1});
          end
        endcase
        have_cur = 1'b1;
      end
      r1 = $urandom;
      if (bus.dmem_req) begin
        if (wleft < 0) wleft = $urandom_range(0, 3);
        if (wleft == 0) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = mem[bus.dmem_addr[3:0]];
          wleft = -1;
        end else begin
          bus.dmem_ack   = 1'b0;
          bus.dmem_rdata = r1[15:0];
          wleft--;
        end
      end else begin
        bus.dmem_ack   = ($urandom_range(0, 5) == 0);
        bus.dmem_rdata = r1[15:0];
      end
      settle();
      if (!wb_valid) begin
        n_cmp++;
        if (wb_reg_write !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_rw_on_bubble cyc%0d: got rw=%b expected 0", cyc, wb_reg_write);
        end
      end else begin
        n_cmp++;
        if (wbq.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_wb_extra cyc%0d: got wb_valid=1 expected no writeback", cyc);
        end else begin
          e = wbq.pop_front();
          if ({wb_data, wb_rd, wb_reg_write, wb_reg_store} !== {e.data, e.rd, e.rw, e.rs}) begin
            n_fail++;
            $display("FAIL rnd_wb cyc%0d: got data=%h rd=%h rw=%b rs=%b expected %h %h %b %b",
                     cyc, wb_data, wb_rd, wb_reg_write, wb_reg_store, e.data, e.rd, e.rw, e.rs);
          end
        end
      end
      if (bus.dmem_req) begin
        n_cmp++;
        if (mq.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_req_extra cyc%0d: got dmem_req=1 expected no request", cyc);
        end else begin
          m = mq[0];
          if ({bus.dmem_addr, bus.dmem_wdata, bus.dmem_we} !== {m.addr, m.wdata, m.we}) begin
            n_fail++;
            $display("FAIL rnd_req cyc%0d: got addr=%h wdata=%h we=%b expected %h %h %b",
                     cyc, bus.dmem_addr, bus.dmem_wdata, bus.dmem_we, m.addr, m.wdata, m.we);
          end
          if (bus.dmem_ack) begin
            void'(mq.pop_front());
            if (bus.dmem_we) mem[bus.dmem_addr[3:0]] = bus.dmem_wdata;
          end
        end
      end
      if (!mem_stall) have_cur = 1'b0;
      tick();
    end
    bus.dmem_ack = 1'b0;
    n_cmp++;
    if (wbq.size() != 0 || mq.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d writebacks and %0d requests outstanding expected 0 0",
               wbq.size(), mq.size());
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    reset = 1'b1;
    bubble_ex();
    tbus.dmem_ack = 1'b0;
    bus.dmem_ack  = 1'b0;
    tick();
    reset = 1'b0;
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 16'h0002);
    settle();
    n_cmp++;
    if ({t_fault, t_stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_accept: got fault=%b stall=%b expected 0 1", t_fault, t_stall);
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      settle();
      n_cmp++;
      if ({tbus.dmem_req, t_wb_valid, t_fault} !== 3'b100) begin
        n_fail++;
        $display("FAIL to_wait c%0d: got req=%b v=%b fault=%b expected 1 0 0",
                 c, tbus.dmem_req, t_wb_valid, t_fault);
      end
      tick();
    end
    bubble_ex();
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++;
      if ({tbus.dmem_req, t_wb_valid, t_stall, t_fault} !== 4'b0001) begin
        n_fail++;
        $display("FAIL to_abort c%0d: got req=%b v=%b stall=%b fault=%b expected 0 0 0 1",
                 c, tbus.dmem_req, t_wb_valid, t_stall, t_fault);
      end
      tick();
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bubble_ex();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tbus.dmem_ack   = 1'b0;
    tbus.dmem_rdata = '0;
`endif
    test_reset();
    test_alu_op();
    test_load_delay();
    test_store_same_cycle();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
